// File: rtl/toggle_decoder_pkg.sv
//------------------------------------------------------------------------------
// Module  : toggle_dec_pkg
// Brief   : Shared types and helpers for the toggle-line decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package toggle_dec_pkg;

  // Glitch-filter FSM encoding
  localparam int STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_STABLE  = 1'b0,
    ST_CONFIRM = 1'b1
  } state_t;

  // Mismatch counter width: must hold values up to FILT_CYC-1 with headroom
  function automatic int fcnt_width(input int filt_cyc);
    return $clog2(filt_cyc) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_decoder_if.sv
//------------------------------------------------------------------------------
// Module  : toggle_decoder_if
// Brief   : Event-line and result bundle between a toggle-line source/consumer
//           (master) and the decoder (slave).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface toggle_decoder_if #(
  parameter int CNT_W = 8
);
  logic             t_in;
  logic             clr;
  logic             pulse;
  logic             level;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (
    output t_in,
    output clr,
    input  pulse,
    input  level,
    input  count,
    input  ovf
  );

  modport slave (
    input  t_in,
    input  clr,
    output pulse,
    output level,
    output count,
    output ovf
  );
endinterface

`default_nettype wire

// File: rtl/toggle_decoder_bit_sync.sv
//------------------------------------------------------------------------------
// Module  : bit_sync
// Brief   : Single-bit multi-flop synchronizer, async active-high reset to 0.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/toggle_decoder.sv
//------------------------------------------------------------------------------
// Module  : toggle_decoder
// Brief   : Turns each flip of a toggle-encoded event line into a 1-cycle
//           pulse. Synchronizes the line, rejects short excursions with a
//           confirm FSM and tracks the accepted level.
//           Optional saturating event counter enabled by TOGGLE_DEC_CNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module toggle_decoder
  import toggle_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  toggle_decoder_if.slave      bus
);

  localparam int               FCNT_W    = fcnt_width(FILT_CYC);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_CYC - 1);

  logic              s;
  state_t            state;
  state_t            state_nxt;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] fcnt_nxt;
  logic              commit;
  logic              level_r;
  logic              pulse_r;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.t_in),
    .q     (s)
  );

  // FSM and mismatch counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_STABLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Confirm a new level only after it holds for FILT_CYC synchronized cycles
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    commit    = 1'b0;
    case (state)
      ST_STABLE: begin
        if (s != level_r) begin
          if (FILT_CYC == 1) begin
            commit = 1'b1;
          end else begin
            state_nxt = ST_CONFIRM;
            fcnt_nxt  = FCNT_W'(1);
          end
        end
      end
      ST_CONFIRM: begin
        if (s == level_r) begin
          state_nxt = ST_STABLE;
          fcnt_nxt  = '0;
        end else if (fcnt == FCNT_LAST) begin
          commit    = 1'b1;
          state_nxt = ST_STABLE;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt  = fcnt + FCNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_STABLE;
        fcnt_nxt  = '0;
      end
    endcase
  end

  // Accepted level flips and a single-cycle pulse is issued on each commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      pulse_r <= commit;
      if (commit) level_r <= ~level_r;
    end
  end

  assign bus.pulse = pulse_r;
  assign bus.level = level_r;

`ifdef TOGGLE_DEC_CNT_EN
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;

  // Saturating event counter; clr wins but a coincident event is still counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else if (bus.clr) begin
      count_r <= commit ? CNT_W'(1) : '0;
      ovf_r   <= 1'b0;
    end else if (commit) begin
      if (&count_r) ovf_r   <= 1'b1;
      else          count_r <= count_r + CNT_W'(1);
    end
  end

  assign bus.count = count_r;
  assign bus.ovf   = ovf_r;
`else
  logic unused_clr;

  assign unused_clr = bus.clr;
  assign bus.count  = '0;
  assign bus.ovf    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_toggle_decoder.sv
//------------------------------------------------------------------------------
// Module  : tb_toggle_decoder
// Brief   : Self-checking bench for toggle_decoder. Expected pulses are queued
//           when the line is toggled and compared when the DUT pulses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_toggle_decoder;
  import toggle_dec_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYC    = 2;
  localparam int CNT_W       = 4;
  // Edge count (relative to the driving negedge) at which a commit appears
  localparam int LAT         = SYNC_STAGES + FILT_CYC;
`ifdef TOGGLE_DEC_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int               cyc;
    logic             lvl;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   edge_cnt;
  int   checks;
  int   errors;
  exp_t q[$];

  logic             lvl_m;
  logic [CNT_W-1:0] cnt_m;
  logic             ovf_m;

  toggle_decoder_if #(.CNT_W(CNT_W)) bus ();

  toggle_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYC    (FILT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Record the commit this toggle should produce, updating the reference counter
  task automatic push_exp(input bit with_clr);
    exp_t e;
    lvl_m = ~lvl_m;
    if (CNT_EN) begin
      if (with_clr) begin
        cnt_m = CNT_W'(1);
        ovf_m = 1'b0;
      end else if (cnt_m == {CNT_W{1'b1}}) begin
        ovf_m = 1'b1;
      end else begin
        cnt_m = cnt_m + CNT_W'(1);
      end
    end
    e.cyc = edge_cnt + LAT;
    e.lvl = lvl_m;
    e.cnt = cnt_m;
    e.ovf = ovf_m;
    q.push_back(e);
  endtask

  task automatic toggle(input bit push);
    @(negedge clk);
    bus.t_in = ~bus.t_in;
    if (push) push_exp(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    bus.t_in = 1'b0;
    bus.clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("q_empty_at_reset", q.size(), 0);
    q.delete();
    reset = 1'b0;
    lvl_m = 1'b0;
    cnt_m = '0;
    ovf_m = 1'b0;
  endtask

  // Scoreboard: compare on every negedge out of reset
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() != 0 && edge_cnt >= q[0].cyc) begin
        exp_t e;
        e = q.pop_front();
        check("pulse_hi",  bus.pulse, 1);
        check("pulse_lvl", bus.level, e.lvl);
        check("pulse_cnt", bus.count, e.cnt);
        check("pulse_ovf", bus.ovf,   e.ovf);
      end else begin
        check("no_pulse", bus.pulse, 0);
      end
    end
  end

  initial begin
    edge_cnt = 0;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.t_in = 1'b0;
    bus.clr  = 1'b0;
    lvl_m    = 1'b0;
    cnt_m    = '0;
    ovf_m    = 1'b0;

    // 1: reset state held for 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_pulse", bus.pulse, 0);
      check("t1_level", bus.level, 0);
      check("t1_count", bus.count, 0);
      check("t1_ovf",   bus.ovf,   0);
    end

    // 2: single toggle, exact latency
    toggle(1'b1);
    repeat (3) @(negedge clk);
    check("t2_level_pre", bus.level, 0);
    repeat (5) @(negedge clk);
    check("t2_level_post", bus.level, 1);
    check("t2_count", bus.count, CNT_EN ? 1 : 0);

    // 3: one-cycle glitch is rejected
    do_reset();
    @(negedge clk);
    bus.t_in = 1'b1;
    @(negedge clk);
    bus.t_in = 1'b0;
    repeat (8) @(negedge clk);
    check("t3_level", bus.level, 0);
    check("t3_count", bus.count, 0);
    check("t3_state", 32'(dut.state), 32'(ST_STABLE));

    // 4: train of 20 toggles 4 cycles apart, counter saturates
    do_reset();
    for (int i = 0; i < 20; i++) begin
      toggle(1'b1);
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("t4_level", bus.level, 0);
    check("t4_count", bus.count, CNT_EN ? 32'hF : 0);
    check("t4_ovf",   bus.ovf,   CNT_EN ? 1 : 0);
    // clr alone
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    cnt_m   = '0;
    ovf_m   = 1'b0;
    check("t4_clr_count", bus.count, 0);
    check("t4_clr_ovf",   bus.ovf,   0);

    // 5: clr coincident with a commit at count=5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      toggle(1'b1);
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("t5_count_pre", bus.count, CNT_EN ? 5 : 0);
    @(negedge clk);
    bus.t_in = ~bus.t_in;
    push_exp(1'b1);
    repeat (LAT - 1) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("t5_count", bus.count, CNT_EN ? 1 : 0);
    check("t5_ovf",   bus.ovf,   0);

    // 6: reset while the FSM is confirming, line still high at release
    do_reset();
    toggle(1'b0);
    repeat (3) @(negedge clk);
    check("t6_in_confirm", 32'(dut.state), 32'(ST_CONFIRM));
    reset = 1'b1;
    #1;
    check("t6_state_rst", 32'(dut.state), 32'(ST_STABLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_pulse_rst", bus.pulse, 0);
      check("t6_level_rst", bus.level, 0);
    end
    reset = 1'b0;
    lvl_m = 1'b0;
    cnt_m = '0;
    ovf_m = 1'b0;
    push_exp(1'b0);
    repeat (8) @(negedge clk);
    check("t6_level", bus.level, 1);

    // 7: asynchronous reset drops a live pulse without a clock edge
    toggle(1'b1);
    repeat (LAT) @(posedge clk);
    #1;
    check("t7_pulse_live", bus.pulse, 1);
    reset = 1'b1;
    #1;
    check("t7_pulse_drop", bus.pulse, 0);
    check("t7_level_drop", bus.level, 0);
    void'(q.pop_front());
    @(negedge clk);
    bus.t_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    lvl_m = 1'b0;
    cnt_m = '0;
    ovf_m = 1'b0;

    repeat (10) @(negedge clk);
    check("q_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
